sync_fifo_wrap: RTL and testbench
=================================

// Module: sync_fifo_wrap
// PURPOSE
// - Single-clock FIFO buffer behind the FIFO wrapper boundary.
// - Accepts words on push and returns them in order on pop.
// - Reports full/empty plus occupancy and error pulses.
// - Sits between a producer and a consumer in the same clock domain.
// - The bus bundle (afifo_if, modport mdr) is flattened into the ports below.
// PARAMETERS
// - DATA_W  8   width of each stored word (fifo_pkg::data_t)
// - DEPTH   16  number of entries; power of 2, >= 2
// - AW      $clog2(DEPTH)  derived; do not override
// PORTS
// - clk        in   1         single clock; both sides sample on the rising edge
// - rst        in   1         synchronous reset, active-high
// - push       in   1         write request
// - data_in    in   DATA_W    write data, sampled when push is accepted
// - pop        in   1         read request
// - data_out   out  DATA_W    read data, registered
// - full       out  1         DEPTH entries stored
// - empty      out  1         0 entries stored
// - count      out  AW+1      current occupancy, 0..DEPTH
// - overflow   out  1         1-cycle pulse: push while full
// - underflow  out  1         1-cycle pulse: pop while empty
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: clk edge with rst=1 sets:
//   - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0
//   - data_out=0, overflow=0, underflow=0
//   - memory contents are not cleared
//   - reset mid-operation discards all stored words
// - Pointers: AW+1 bits each; the MSB is the wrap bit.
//   - empty = (wr_ptr == rd_ptr)
//   - full  = addresses equal and MSBs differ
//   - both flags are decoded combinationally from the registered pointers
// - Push accepted iff push && !full.
//   - mem[wr_ptr[AW-1:0]] <= data_in; wr_ptr++ (wraps modulo 2*DEPTH)
// - Pop accepted iff pop && !empty.
//   - data_out <= mem[rd_ptr[AW-1:0]] on that edge, so data is valid the cycle after pop
//   - rd_ptr++
//   - when pop is not accepted, data_out holds its value
// - Simultaneous push and pop:
//   - non-empty and non-full: both accepted; count unchanged
//   - empty: pop rejected (underflow pulse); push accepted
//   - full: push rejected (overflow pulse); pop accepted
//   - no write-through: a word written this cycle is never read in the same cycle
// - count: +1 on accepted push only, -1 on accepted pop only; never exceeds DEPTH or drops below 0.
// - overflow/underflow: registered, high for exactly one cycle after the offending edge.
//   - the rejected operation changes no state
// STRUCTURE
// - fifo_pkg: data_t (logic [DATA_W-1:0]), DATA_W, DEPTH constants.
// - afifo_tb_pkg: bit_t alias shared with benches.
// - Sub-module fifo_mem: DEPTH x DATA_W RAM.
//   - synchronous write port; synchronous registered read port
//   - instantiated once
// - Pointer, flag, count and error logic live in sync_fifo_wrap.
// TESTING
// - Reset: hold rst=1 two cycles -> empty=1, full=0, count=0, data_out=0.
// - Order: push 0x11,0x22,0x33, then pop x3 -> data_out 0x11,0x22,0x33, each one cycle after its pop; empty=1 at end.
// - Fill: 16 pushes of 0x00..0x0F -> full=1, count=16.
//   - 17th push 0xAA -> overflow pulses 1 cycle; 16 pops return 0x00..0x0F, no 0xAA.
// - Underflow: pop on empty FIFO -> underflow pulses once; data_out and count unchanged.
// - Concurrent:
//   - with count=5, push+pop for 20 cycles -> count stays 5, pointers wrap, data stays in order
//   - with full, push+pop -> pop accepted, overflow=1, count=15
// - Mid reset: with count=7, assert rst one cycle -> count=0, empty=1; next push/pop pair returns the newly pushed word.

Source files
------------

// File: rtl/afifo_tb_pkg.sv
// afifo_tb_pkg: two-state bit alias shared with benches
package afifo_tb_pkg;
  typedef bit bit_t;
endpackage

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word type and default geometry for the sync FIFO
package fifo_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 16;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W RAM with synchronous write and registered read port
module fifo_mem #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH = fifo_pkg::DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the read register is reset; array contents survive reset
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_wrap.sv
// sync_fifo_wrap: single-clock FIFO with wrap-bit pointers, occupancy and error pulses
module sync_fifo_wrap #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH = fifo_pkg::DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count = wr_ptr - rd_ptr;
    do_push = push && !full;
    do_pop = pop && !empty;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
      overflow <= push && full;
      underflow <= pop && empty;
    end
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(do_push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(data_in),
    .re(do_pop),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(data_out)
  );
endmodule

// File: tb/tb_sync_fifo_wrap.sv
// tb_sync_fifo_wrap: scenario tasks against a queue model and read-data scoreboard
module tb_sync_fifo_wrap;
  import afifo_tb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic full, empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_q[$];
  logic [7:0] sb[$];
  logic [7:0] exp_dout = '0;
  logic exp_ovf, exp_unf;
  sync_fifo_wrap dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic drive(input bit_t p, input logic [7:0] d, input bit_t q);
    @(negedge clk);
    push = p; data_in = d; pop = q;
    exp_ovf = p && m_q.size() == 16;
    exp_unf = q && m_q.size() == 0;
    if (q && m_q.size() > 0) sb.push_back(m_q.pop_front());
    if (p && !exp_ovf) m_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete(); sb.delete(); exp_dout = '0;
  endtask
  task automatic check_pop(input string name);
    logic [7:0] e;
    e = sb.pop_front();
    exp_dout = e;
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL %s data_out got %h exp %h", name, data_out, e); end
  endtask
  task automatic test_reset();
    do_reset(2);
    checks += 5;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", data_out); end
    if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
  endtask
  task automatic test_order();
    logic [7:0] v[3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) drive(1, v[i], 0);
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL order_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1);
      check_pop("order");
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b exp 1", empty); end
  endtask
  task automatic test_fill();
    do_reset(1);
    for (int i = 0; i < 16; i++) drive(1, 8'(i), 0);
    checks += 2;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    if (count !== 5'(m_q.size())) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, m_q.size()); end
    drive(1, 8'hAA, 0);
    checks += 2;
    if (overflow !== exp_ovf) begin errors++; $display("FAIL fill_ovf got %b exp %b", overflow, exp_ovf); end
    if (count !== 5'd16) begin errors++; $display("FAIL fill_ovf_count got %0d exp 16", count); end
    drive(0, 8'h00, 0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clear got %b exp 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'h00, 1);
      check_pop("fill_drain");
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %b exp 1", empty); end
  endtask
  task automatic test_underflow();
    drive(0, 8'h00, 1);
    checks += 3;
    if (underflow !== exp_unf) begin errors++; $display("FAIL unf_pulse got %b exp %b", underflow, exp_unf); end
    if (data_out !== exp_dout) begin errors++; $display("FAIL unf_dout got %h exp %h", data_out, exp_dout); end
    if (count !== 5'd0) begin errors++; $display("FAIL unf_count got %0d exp 0", count); end
    drive(0, 8'h00, 0);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", underflow); end
  endtask
  task automatic test_concurrent();
    do_reset(1);
    for (int i = 0; i < 5; i++) drive(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'h80 + 8'(i), 1);
      check_pop("conc");
      checks++;
      if (count !== 5'd5) begin errors++; $display("FAIL conc_count got %0d exp 5", count); end
    end
    for (int i = 0; i < 11; i++) drive(1, 8'hC0 + 8'(i), 0);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL conc_full got %b exp 1", full); end
    drive(1, 8'hEE, 1);
    check_pop("conc_full");
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL conc_ovf got %b exp 1", overflow); end
    if (count !== 5'(m_q.size())) begin errors++; $display("FAIL conc_full_count got %0d exp %0d", count, m_q.size()); end
  endtask
  task automatic test_mid_reset();
    do_reset(1);
    for (int i = 0; i < 7; i++) drive(1, 8'h60 + 8'(i), 0);
    checks++;
    if (count !== 5'd7) begin errors++; $display("FAIL mid_pre_count got %0d exp 7", count); end
    do_reset(1);
    checks += 2;
    if (count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
    drive(1, 8'h5A, 0);
    drive(0, 8'h00, 1);
    check_pop("mid_new_word");
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL mid_end_empty got %b exp 1", empty); end
  endtask
  initial begin
    test_reset();
    test_order();
    test_fill();
    test_underflow();
    test_concurrent();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
